// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state type and baud divider helper
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    // Sample-counter positions inside one bit period: the three centre samples
    // used for the majority vote and the last count of the bit.
    localparam logic [3:0] SAMPLE_LO  = 4'd7;
    localparam logic [3:0] SAMPLE_MID = 4'd8;
    localparam logic [3:0] SAMPLE_HI  = 4'd9;
    localparam logic [3:0] BIT_END    = 4'd15;

    localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

    // Clocks per oversample tick, truncated.
    function automatic int uart_div(input int clk_freq, input int baud_rate, input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator (DIV clocks per tick), held at 0 when idle
//
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   run   - counter runs while high; low holds the counter at 0
//   tick  - one-clock pulse when the counter is at DIV-1
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ       = 50000000,
    parameter int BAUD_RATE      = 9600,
    parameter int TICKS_PER_BIT  = OVERSAMPLE
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, TICKS_PER_BIT);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 16x oversampling UART receiver with valid/ready byte output
//
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   rx_enable       - receiver enable; low aborts any frame in progress
//   uart_rx         - asynchronous serial line (idles high)
//   rx_ready        - consumer handshake
//   rx_data         - received byte, stable while rx_valid
//   rx_valid        - a byte is pending
//   rx_busy         - receiver is inside a frame (FSM not idle)
//   parity_error    - parity mismatch on the pending byte
//   framing_error   - stop bit sampled low on the pending byte
//   overrun_error   - a frame was dropped while the pending byte was unread
//   rx_error        - OR of the three error flags
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic       uart_rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       parity_error,
    output logic       framing_error,
    output logic       overrun_error,
    output logic       rx_error
);

    localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);
    localparam logic PAR_EN_BIT  = (PARITY_EN != 0);

    // Line synchroniser and edge detect; all preset to the idle level.
    logic [1:0] sync_q;
    logic       rx_prev;
    logic       rx_s;
    logic       fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], uart_rx};
            rx_prev <= sync_q[1];
        end
    end

    assign rx_s = sync_q[1];
    assign fall = rx_prev && !rx_s;

    uart_state_t state;
    logic [3:0]  sample_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        samp_lo;
    logic        samp_mid;
    logic        par_err_r;
    logic        frame_done;
    logic        frame_ferr;
    logic        tick;
    logic        vote;
    logic        par_expect;

    uart_baud_tick #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD_RATE     (BAUD_RATE),
        .TICKS_PER_BIT (OVERSAMPLE)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .run   (state != ST_IDLE),
        .tick  (tick)
    );

    // Majority of the samples at counts 7, 8 and the live sample at count 9;
    // only meaningful on the tick where sample_cnt == SAMPLE_HI.
    assign vote       = (samp_lo & samp_mid) | (samp_lo & rx_s) | (samp_mid & rx_s);
    assign par_expect = (^shift_reg) ^ PAR_ODD_BIT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            samp_lo    <= 1'b0;
            samp_mid   <= 1'b0;
            par_err_r  <= 1'b0;
            frame_done <= 1'b0;
            frame_ferr <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!rx_enable) begin
                state      <= ST_IDLE;
                sample_cnt <= '0;
                bit_cnt    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fall) begin
                            state      <= ST_START;
                            sample_cnt <= '0;
                            bit_cnt    <= '0;
                            par_err_r  <= 1'b0;
                        end
                    end
                    ST_BREAK: begin
                        // A held-low line must go high before another start edge counts.
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        if (tick) begin
                            sample_cnt <= sample_cnt + 4'd1;
                            if (sample_cnt == SAMPLE_LO) begin
                                samp_lo <= rx_s;
                            end
                            if (sample_cnt == SAMPLE_MID) begin
                                samp_mid <= rx_s;
                            end
                            if (sample_cnt == SAMPLE_HI) begin
                                case (state)
                                    ST_START: begin
                                        if (vote) begin
                                            state      <= ST_IDLE;
                                            sample_cnt <= '0;
                                        end
                                    end
                                    ST_DATA: begin
                                        shift_reg <= {vote, shift_reg[7:1]};
                                    end
                                    ST_PARITY: begin
                                        par_err_r <= vote ^ par_expect;
                                    end
                                    ST_STOP: begin
                                        // Decide mid stop bit so back-to-back frames are not missed.
                                        frame_done <= 1'b1;
                                        frame_ferr <= !vote;
                                        state      <= vote ? ST_IDLE : ST_BREAK;
                                        sample_cnt <= '0;
                                    end
                                    default: ;
                                endcase
                            end
                            if (sample_cnt == BIT_END) begin
                                case (state)
                                    ST_START: begin
                                        state   <= ST_DATA;
                                        bit_cnt <= '0;
                                    end
                                    ST_DATA: begin
                                        if (bit_cnt == LAST_DATA_BIT) begin
                                            state <= PAR_EN_BIT ? ST_PARITY : ST_STOP;
                                        end else begin
                                            bit_cnt <= bit_cnt + 3'd1;
                                        end
                                    end
                                    ST_PARITY: begin
                                        state <= ST_STOP;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Output holding register. A delivery in the same cycle as an acceptance
    // replaces the old byte rather than counting as an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else if (frame_done && (!rx_valid || rx_ready)) begin
            rx_data       <= shift_reg;
            rx_valid      <= 1'b1;
            parity_error  <= par_err_r;
            framing_error <= frame_ferr;
            overrun_error <= 1'b0;
        end else if (frame_done) begin
            overrun_error <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end
    end

    assign rx_busy  = (state != ST_IDLE);
    assign rx_error = parity_error | framing_error | overrun_error;

endmodule
